regfile_sb: RTL

Parametrised successor to the CPU register file. It is sized by DATA_W/NUM_REGS and has two write ports: the ALU writeback and the memory-load return. It adds an optional hard-wired zero register, same-cycle read-after-write bypass, and a pending-load scoreboard. The scoreboard gives the decode/stall logic per-port busy flags, an outstanding-load count and a sticky protocol-error flag. It sits between decode, ALU writeback and the memory interface.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 81 ++++++++
 rtl/regfile_sb.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing helpers and default dimensions for the regfile_sb register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_NUM_REGS = 16;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return addr_w(n) + 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: per-register pending bits, read-port busy flags,
// outstanding-load count and a sticky protocol-error flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter bit          R0_ZERO  = 1'b0,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned ADDR_W  = addr_w(NUM_REGS),
    localparam int unsigned CNT_W   = cnt_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] raddrA,
    input  logic [ADDR_W-1:0] raddrB,
    output logic              busyA,
    output logic              busyB,
    output logic [CNT_W-1:0]  pend_cnt,
    output logic              err
);

    logic [NUM_REGS-1:0] r_pend;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    logic w_set_vld;
    logic w_clr_vld;
    logic w_same;
    logic w_inc;
    logic w_dec;
    logic w_err_ld;
    logic w_err_set;

    assign w_set_vld = pend_set && !(R0_ZERO && pend_addr == '0);
    assign w_clr_vld = ld_valid && !(R0_ZERO && ld_addr == '0);
    assign w_same    = w_set_vld && w_clr_vld && (pend_addr == ld_addr);

    // A set and a clear of the same bit cancel: the bit stays set, count unchanged.
    assign w_inc     = w_set_vld && !r_pend[pend_addr];
    assign w_dec     = w_clr_vld && r_pend[ld_addr] && !w_same;

    assign w_err_ld  = w_clr_vld && !r_pend[ld_addr];
    assign w_err_set = w_set_vld && r_pend[pend_addr] && !w_same;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_set_vld && pend_addr == ADDR_W'(i)) begin
                    r_pend[i] <= 1'b1;
                end else if (w_clr_vld && ld_addr == ADDR_W'(i)) begin
                    r_pend[i] <= 1'b0;
                end
            end
            if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_err_ld || w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busyA = r_pend[raddrA] && !(BYPASS && ld_valid && ld_addr == raddrA)
                   && !(R0_ZERO && raddrA == '0);
    assign busyB = r_pend[raddrB] && !(BYPASS && ld_valid && ld_addr == raddrB)
                   && !(R0_ZERO && raddrB == '0);

    assign pend_cnt = r_cnt;
    assign err      = r_err;

endmodule

// File: rtl/regfile_sb.sv
// Two-write-port register file (ALU writeback + load return) with optional
// zero register, same-cycle read bypass and a pending-load scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter bit          R0_ZERO  = 1'b0,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned ADDR_W  = addr_w(NUM_REGS),
    localparam int unsigned CNT_W   = cnt_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] raddrA,
    input  logic [ADDR_W-1:0] raddrB,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    output logic              busyA,
    output logic              busyB,
    output logic [CNT_W-1:0]  pend_cnt,
    output logic              err
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_wen_ok;
    logic              w_ld_ok;
    logic [DATA_W-1:0] w_rdA;
    logic [DATA_W-1:0] w_rdB;

    assign w_wen_ok = wen && !(R0_ZERO && waddr == '0);
    assign w_ld_ok  = ld_valid && !(R0_ZERO && ld_addr == '0);

    // On an address collision the ALU result is younger and wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_ld_ok && !(w_wen_ok && waddr == ld_addr)) begin
                r_mem[ld_addr] <= ld_data;
            end
            if (w_wen_ok) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    always_comb begin
        w_rdA = r_mem[raddrA];
        if (BYPASS) begin
            if (w_wen_ok && waddr == raddrA) begin
                w_rdA = wdata;
            end else if (w_ld_ok && ld_addr == raddrA) begin
                w_rdA = ld_data;
            end
        end
        if (R0_ZERO && raddrA == '0) begin
            w_rdA = '0;
        end
    end

    always_comb begin
        w_rdB = r_mem[raddrB];
        if (BYPASS) begin
            if (w_wen_ok && waddr == raddrB) begin
                w_rdB = wdata;
            end else if (w_ld_ok && ld_addr == raddrB) begin
                w_rdB = ld_data;
            end
        end
        if (R0_ZERO && raddrB == '0) begin
            w_rdB = '0;
        end
    end

    assign rdataA = w_rdA;
    assign rdataB = w_rdB;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .R0_ZERO  (R0_ZERO),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .raddrA    (raddrA),
        .raddrB    (raddrB),
        .busyA     (busyA),
        .busyB     (busyB),
        .pend_cnt  (pend_cnt),
        .err       (err)
    );

endmodule
